// File: rtl/led_frame_receiver.sv
// Two-lane LED frame receiver: drives the byte clock, samples both 8-bit lanes once
// per beat and publishes the assembled grid frame with a one-cycle valid strobe.
module led_frame_receiver #(
  parameter int HALF  = 4,
  parameter int SYNC  = 2,
  parameter int BEATS = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    frame_start,
  input  logic [7:0]              lane0,
  input  logic [7:0]              lane1,
  output logic                    byte_clk,
  output logic [16*BEATS-1:0]     grid_out,
  output logic                    frame_valid,
  output logic                    busy,
  output logic                    error
);

  localparam int GRID_W = 16 * BEATS;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [7:0]        HALF_LAST = 8'(HALF - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, HI, LO, DONE} state_t;

  state_t              state;
  logic [SYNC-1:0]     fs_sync;
  logic                fs_prev;
  logic [7:0]          lane0_sync [SYNC];
  logic [7:0]          lane1_sync [SYNC];
  logic [BEAT_W-1:0]   beat;
  logic [7:0]          phase;
  logic [GRID_W-1:0]   shift;
  logic                fs_s;
  logic                start_edge;

  // Start synchroniser and edge history reset to ones, so a frame_start already
  // high at reset release never looks like a 0->1 edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fs_sync <= '1;
    end else begin
      fs_sync <= {fs_sync[SYNC-2:0], frame_start};
    end
  end

  always_ff @(posedge clock) begin
    lane0_sync[0] <= lane0;
    lane1_sync[0] <= lane1;
    for (int i = 1; i < SYNC; i++) begin
      lane0_sync[i] <= lane0_sync[i-1];
      lane1_sync[i] <= lane1_sync[i-1];
    end
  end

  assign fs_s       = fs_sync[SYNC-1];
  assign start_edge = fs_s && !fs_prev;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      byte_clk    <= 1'b0;
      grid_out    <= '0;
      frame_valid <= 1'b0;
      busy        <= 1'b0;
      error       <= 1'b0;
      beat        <= '0;
      phase       <= '0;
      shift       <= '0;
      fs_prev     <= 1'b1;
    end else begin
      fs_prev     <= fs_s;
      frame_valid <= 1'b0;
      case (state)
        IDLE: begin
          byte_clk <= 1'b0;
          busy     <= 1'b0;
          if (start_edge) begin
            beat     <= '0;
            phase    <= '0;
            shift    <= '0;
            busy     <= 1'b1;
            byte_clk <= 1'b1;
            state    <= HI;
          end
        end
        HI: begin
          if (!fs_s) begin
            byte_clk <= 1'b0;
            busy     <= 1'b0;
            error    <= 1'b1;
            state    <= IDLE;
          end else if (phase == HALF_LAST) begin
            // Lanes are stable here: the transmitter only moves them on byte_clk rise.
            shift[8*int'(beat) +: 8]            <= lane0_sync[SYNC-1];
            shift[GRID_W/2 + 8*int'(beat) +: 8] <= lane1_sync[SYNC-1];
            phase    <= '0;
            byte_clk <= 1'b0;
            state    <= LO;
          end else begin
            phase <= phase + 8'd1;
          end
        end
        LO: begin
          if (!fs_s) begin
            byte_clk <= 1'b0;
            busy     <= 1'b0;
            error    <= 1'b1;
            state    <= IDLE;
          end else if (phase == HALF_LAST) begin
            phase <= '0;
            if (beat == BEAT_LAST) begin
              // Outputs are registered on entry so they are visible during DONE.
              grid_out    <= shift;
              frame_valid <= 1'b1;
              error       <= 1'b0;
              busy        <= 1'b0;
              state       <= DONE;
            end else begin
              beat     <= beat + 1'b1;
              byte_clk <= 1'b1;
              state    <= HI;
            end
          end else begin
            phase <= phase + 8'd1;
          end
        end
        DONE: begin
          beat  <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
